// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions for the writeback stage: load funct3 encodings
// and the writeback FSM state type.
package rv32i_pkg;

   localparam logic [2:0] LOAD_LB  = 3'b000;
   localparam logic [2:0] LOAD_LH  = 3'b001;
   localparam logic [2:0] LOAD_LW  = 3'b010;
   localparam logic [2:0] LOAD_LBU = 3'b100;
   localparam logic [2:0] LOAD_LHU = 3'b101;

   typedef enum logic {
      WB_IDLE,
      WB_WAIT_LOAD
   } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: picks the addressed byte/halfword out of the raw
// memory word and sign- or zero-extends it; flags funct3 codes that are not loads.
module load_align
   import rv32i_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] data,
   output logic            illegal
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Halfword selection uses only addr_lo[1]; misaligned halfwords never reach here.
   assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
   assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      data    = '0;
      illegal = 1'b0;
      case (funct3)
         LOAD_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         LOAD_LH:  data = {{(XLEN-16){half_sel[15]}}, half_sel};
         LOAD_LW:  data = rdata;
         LOAD_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
         LOAD_LHU: data = {{(XLEN-16){1'b0}}, half_sel};
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/wbunit.sv
// rv32i writeback stage: accepts retiring instructions from MEM, waits for load
// data, writes the register file, drives forwarding and counts retirements.
module wbunit
   import rv32i_pkg::*;
#(
   parameter int  XLEN          = 32,
   parameter int  NREGS         = 32,
   parameter int  MAX_LOAD_WAIT = 15,
   parameter int  CNT_W         = 64,
   localparam int RADDR_W       = $clog2(NREGS)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic               mem_valid_i,
   output logic               mem_ready_o,
   input  logic [RADDR_W-1:0] mem_rd_i,
   input  logic               mem_rd_we_i,
   input  logic               mem_is_load_i,
   input  logic [2:0]         mem_funct3_i,
   input  logic [1:0]         mem_addr_lo_i,
   input  logic [XLEN-1:0]    mem_result_i,
   input  logic               dmem_rvalid_i,
   input  logic [XLEN-1:0]    dmem_rdata_i,
   output logic               rf_we_o,
   output logic [RADDR_W-1:0] rf_waddr_o,
   output logic [XLEN-1:0]    rf_wdata_o,
   output logic               fwd_valid_o,
   output logic               busy_o,
   output logic               load_err_o,
   output logic [CNT_W-1:0]   instret_o
);

   localparam int                WAIT_W    = $clog2(MAX_LOAD_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_LOAD_WAIT - 1);

   wb_state_e          state;
   wb_state_e          state_next;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [RADDR_W-1:0] ld_rd;
   logic               ld_rd_we;
   logic [2:0]         ld_funct3;
   logic [1:0]         ld_addr_lo;
   logic [XLEN-1:0]    aligned;
   logic               illegal;
   logic               in_wait;
   logic               accept;
   logic               load_done;
   logic               load_timeout;

   assign in_wait      = (state == WB_WAIT_LOAD);
   assign accept       = mem_valid_i & mem_ready_o & ~flush_i;
   // Flush outranks a same-cycle rvalid; rvalid on the last allowed cycle beats the timeout.
   assign load_done    = in_wait & ~flush_i & dmem_rvalid_i;
   assign load_timeout = in_wait & ~flush_i & ~dmem_rvalid_i & (wait_cnt == WAIT_LAST);
   assign fwd_valid_o  = rf_we_o;

   load_align #(.XLEN(XLEN)) u_load_align (
      .funct3  (ld_funct3),
      .addr_lo (ld_addr_lo),
      .rdata   (dmem_rdata_i),
      .data    (aligned),
      .illegal (illegal)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= WB_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         WB_IDLE:      if (accept && mem_is_load_i) state_next = WB_WAIT_LOAD;
         WB_WAIT_LOAD: if (flush_i || load_done || load_timeout) state_next = WB_IDLE;
         default:      state_next = WB_IDLE;
      endcase
   end

   always_comb begin
      mem_ready_o = (state == WB_IDLE);
      busy_o      = in_wait;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wait_cnt   <= '0;
         ld_rd      <= '0;
         ld_rd_we   <= 1'b0;
         ld_funct3  <= '0;
         ld_addr_lo <= '0;
         rf_we_o    <= 1'b0;
         rf_waddr_o <= '0;
         rf_wdata_o <= '0;
         load_err_o <= 1'b0;
         instret_o  <= '0;
      end else begin
         // Write enable and error are pulses; address and data hold until the next write.
         rf_we_o    <= 1'b0;
         load_err_o <= 1'b0;

         if (accept) wait_cnt <= '0;
         else if (in_wait) wait_cnt <= wait_cnt + WAIT_W'(1);

         if (accept && mem_is_load_i) begin
            ld_rd      <= mem_rd_i;
            ld_rd_we   <= mem_rd_we_i;
            ld_funct3  <= mem_funct3_i;
            ld_addr_lo <= mem_addr_lo_i;
         end

         if (accept && !mem_is_load_i) begin
            instret_o <= instret_o + CNT_W'(1);
            if (mem_rd_we_i && mem_rd_i != '0) begin
               rf_we_o    <= 1'b1;
               rf_waddr_o <= mem_rd_i;
               rf_wdata_o <= mem_result_i;
            end
         end

         // An illegal funct3 still retires, but never writes.
         if (load_done) begin
            instret_o <= instret_o + CNT_W'(1);
            if (illegal) begin
               load_err_o <= 1'b1;
            end else if (ld_rd_we && ld_rd != '0) begin
               rf_we_o    <= 1'b1;
               rf_waddr_o <= ld_rd;
               rf_wdata_o <= aligned;
            end
         end

         if (load_timeout) load_err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_wbunit.sv
// Scoreboard bench for wbunit: directed cases plus randomized ALU/load/flush/timeout
// traffic, checked against a behavioural model of retirement and load alignment.
module tb_wbunit;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        flush_i;
   logic        mem_valid_i;
   logic        mem_ready_o;
   logic [4:0]  mem_rd_i;
   logic        mem_rd_we_i;
   logic        mem_is_load_i;
   logic [2:0]  mem_funct3_i;
   logic [1:0]  mem_addr_lo_i;
   logic [31:0] mem_result_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic        rf_we_o;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic        fwd_valid_o;
   logic        busy_o;
   logic        load_err_o;
   logic [63:0] instret_o;

   always #5 clk = ~clk;

   wbunit dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .flush_i       (flush_i),
      .mem_valid_i   (mem_valid_i),
      .mem_ready_o   (mem_ready_o),
      .mem_rd_i      (mem_rd_i),
      .mem_rd_we_i   (mem_rd_we_i),
      .mem_is_load_i (mem_is_load_i),
      .mem_funct3_i  (mem_funct3_i),
      .mem_addr_lo_i (mem_addr_lo_i),
      .mem_result_i  (mem_result_i),
      .dmem_rvalid_i (dmem_rvalid_i),
      .dmem_rdata_i  (dmem_rdata_i),
      .rf_we_o       (rf_we_o),
      .rf_waddr_o    (rf_waddr_o),
      .rf_wdata_o    (rf_wdata_o),
      .fwd_valid_o   (fwd_valid_o),
      .busy_o        (busy_o),
      .load_err_o    (load_err_o),
      .instret_o     (instret_o)
   );

   typedef struct {
      bit          is_err;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [63:0] instret;
   } ev_t;

   ev_t             exp_q[$];
   int              n_checks = 0;
   int              n_pass   = 0;
   longint unsigned model_instret = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference: extract the addressed field arithmetically, then extend it.
   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w, output bit bad);
      int unsigned bv = (w >> (8 * a)) & 32'hFF;
      int unsigned hv = (w >> (16 * (a / 2))) & 32'hFFFF;
      bad = 1'b0;
      case (f3)
         3'd0:    return (bv >= 128) ? bv - 256 : bv;
         3'd1:    return (hv >= 32768) ? hv - 65536 : hv;
         3'd2:    return w;
         3'd4:    return bv;
         3'd5:    return hv;
         default: begin bad = 1'b1; return 32'd0; end
      endcase
   endfunction

   task automatic expect_retire(input bit err, input bit writes, input logic [4:0] rd,
                                input logic [31:0] data);
      ev_t e;
      model_instret++;
      if (err || writes) begin
         e.is_err  = err;
         e.addr    = rd;
         e.data    = data;
         e.instret = model_instret;
         exp_q.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (!rst_i && (rf_we_o || load_err_o)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", {rf_we_o, load_err_o}, 2'b00);
         end else begin
            e = exp_q.pop_front();
            check("ev_rf_we", rf_we_o, !e.is_err);
            check("ev_fwd_valid", fwd_valid_o, !e.is_err);
            check("ev_load_err", load_err_o, e.is_err);
            if (!e.is_err) begin
               check("ev_waddr", rf_waddr_o, e.addr);
               check("ev_wdata", rf_wdata_o, e.data);
            end
            check("ev_instret", instret_o, e.instret);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!mem_ready_o && n < 40) begin
         step();
         n++;
      end
      if (!mem_ready_o) check("ready_timeout", mem_ready_o, 1'b1);
   endtask

   task automatic wait_noise();
      mem_valid_i   = 1'($urandom_range(0, 1));
      mem_is_load_i = 1'($urandom_range(0, 1));
      mem_result_i  = $urandom;
      dmem_rdata_i  = $urandom;
   endtask

   task automatic alu_op(input logic [4:0] rd, input bit we, input logic [31:0] res);
      wait_ready();
      mem_valid_i   = 1'b1;
      mem_is_load_i = 1'b0;
      mem_rd_i      = rd;
      mem_rd_we_i   = we;
      mem_result_i  = res;
      dmem_rvalid_i = 1'($urandom_range(0, 1));  // ignored while idle
      expect_retire(1'b0, we && rd != 0, rd, res);
      step();
      mem_valid_i   = 1'b0;
      dmem_rvalid_i = 1'b0;
   endtask

   // mode 0: rvalid after dly wait cycles; 1: no rvalid (timeout); 2: flush after dly, then late rvalid
   task automatic load_op(input logic [4:0] rd, input bit we, input logic [2:0] f3,
                          input logic [1:0] a, input logic [31:0] w, input int dly, input int mode);
      bit          bad;
      logic [31:0] v;
      wait_ready();
      mem_valid_i   = 1'b1;
      mem_is_load_i = 1'b1;
      mem_rd_i      = rd;
      mem_rd_we_i   = we;
      mem_funct3_i  = f3;
      mem_addr_lo_i = a;
      step();
      check("busy_in_wait", {busy_o, mem_ready_o}, 2'b10);
      if (mode == 1) begin
         for (int i = 0; i < 14; i++) begin wait_noise(); step(); end
         mem_valid_i = 1'b0;
         check("busy_before_timeout", busy_o, 1'b1);
         begin
            ev_t e;
            e.is_err = 1'b1; e.addr = '0; e.data = '0; e.instret = model_instret;
            exp_q.push_back(e);
         end
         step();
         check("ready_after_timeout", mem_ready_o, 1'b1);
      end else begin
         for (int i = 0; i < dly; i++) begin wait_noise(); step(); end
         mem_valid_i = 1'b0;
         check("ready_low_at_rvalid", mem_ready_o, 1'b0);
         if (mode == 0) begin
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = w;
            v = ref_load(f3, a, w, bad);
            expect_retire(bad, !bad && we && rd != 0, rd, v);
            step();
            dmem_rvalid_i = 1'b0;
            check("ready_after_rvalid", mem_ready_o, 1'b1);
         end else begin
            flush_i       = 1'b1;
            dmem_rvalid_i = 1'($urandom_range(0, 1));
            step();
            flush_i       = 1'b0;
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = w;
            check("idle_after_flush", {busy_o, mem_ready_o}, 2'b01);
            step();
            dmem_rvalid_i = 1'b0;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_i = 1'b1; flush_i = 1'b0; mem_valid_i = 1'b0; mem_rd_i = '0; mem_rd_we_i = 1'b0;
      mem_is_load_i = 1'b0; mem_funct3_i = '0; mem_addr_lo_i = '0; mem_result_i = '0;
      dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
      step(); step();
      rst_i = 1'b0;
      check("reset_outs", {rf_we_o, fwd_valid_o, busy_o, load_err_o, mem_ready_o}, 5'b00001);
      check("reset_waddr_wdata", {rf_waddr_o, rf_wdata_o}, '0);
      check("reset_instret", instret_o, 64'd0);

      alu_op(5'd5, 1'b1, 32'hDEADBEEF);
      load_op(5'd7, 1'b1, 3'b000, 2'd3, 32'h80123456, 2, 0);   // LB  -> FFFFFF80
      load_op(5'd8, 1'b1, 3'b100, 2'd3, 32'h80123456, 2, 0);   // LBU -> 00000080
      load_op(5'd9, 1'b1, 3'b101, 2'd2, 32'hBEEF1234, 1, 0);   // LHU -> 0000BEEF
      load_op(5'd10, 1'b1, 3'b001, 2'd3, 32'h8001_7FFF, 14, 0); // rvalid on last allowed cycle
      load_op(5'd11, 1'b1, 3'b010, 2'd0, 32'h0, 0, 1);         // timeout
      load_op(5'd12, 1'b1, 3'b010, 2'd0, 32'h1234_5678, 3, 2); // flush + late rvalid
      alu_op(5'd13, 1'b1, 32'hCAFE_F00D);
      load_op(5'd14, 1'b1, 3'b011, 2'd0, 32'h5555_AAAA, 0, 0); // illegal funct3
      alu_op(5'd0, 1'b1, 32'h1111_2222);                        // rd==0: retire, no write

      mem_valid_i = 1'b1; mem_is_load_i = 1'b0; mem_rd_i = 5'd3; mem_rd_we_i = 1'b1;
      flush_i = 1'b1;                                           // flush blocks accept
      step();
      mem_valid_i = 1'b0; flush_i = 1'b0;
      check("flush_blocks_accept", instret_o, model_instret);

      for (int n = 0; n < 160; n++) begin
         int          kind = $urandom_range(0, 9);
         logic [4:0]  rd   = 5'($urandom);
         bit          we   = ($urandom_range(0, 7) != 0);
         logic [2:0]  f3   = 3'($urandom);
         logic [1:0]  a    = 2'($urandom);
         if (kind < 4)       alu_op(rd, we, $urandom);
         else if (kind < 8)  load_op(rd, we, f3, a, $urandom, $urandom_range(0, 14), 0);
         else if (kind == 8) load_op(rd, we, f3, a, $urandom, $urandom_range(0, 13), 2);
         else if (n % 4 == 0) load_op(rd, we, f3, a, $urandom, 0, 1);
         else                alu_op(rd, we, $urandom);
      end

      load_op(5'd6, 1'b1, 3'b010, 2'd0, 32'hFFFF_0000, 0, 1);
      wait_ready();
      mem_valid_i = 1'b1; mem_is_load_i = 1'b1; mem_rd_i = 5'd4; mem_rd_we_i = 1'b1;
      mem_funct3_i = 3'b010;
      step();
      mem_valid_i = 1'b0;
      step(); step();
      rst_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
      step();
      rst_i = 1'b0; dmem_rvalid_i = 1'b0;
      model_instret = 0;
      check("rst_mid_load_outs", {rf_we_o, fwd_valid_o, busy_o, load_err_o, mem_ready_o}, 5'b00001);
      check("rst_mid_load_data", {rf_waddr_o, rf_wdata_o}, '0);
      check("rst_mid_load_instret", instret_o, 64'd0);
      alu_op(5'd21, 1'b1, 32'h0BAD_CAFE);

      step(); step(); step();
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("final_instret", instret_o, model_instret);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
